// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor; two of these plus an OR form the serial full subtractor.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b: one full-subtractor step per RUN cycle, LSB first, result shifted in from the MSB.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             bff;
  logic [CW-1:0]    cnt;

  logic hd1;
  logic hb1;
  logic dbit;
  logic hb2;
  logic bout;

  // Full subtractor: first stage forms ai-bi, second folds in the incoming borrow.
  half_subtractor u_hs0 (
    .x  (sa[0]),
    .y  (sb[0]),
    .d  (hd1),
    .bo (hb1)
  );

  half_subtractor u_hs1 (
    .x  (hd1),
    .y  (bff),
    .d  (dbit),
    .bo (hb2)
  );

  assign bout   = hb1 | hb2;
  assign borrow = bff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      sa    <= '0;
      sb    <= '0;
      bff   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            bff   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          diff <= {dbit, diff[WIDTH-1:1]};
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          bff  <= bout;
          cnt  <= cnt + CW'(1);
          // Counter reaches WIDTH on the final step, which still fits in CW bits.
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against a plain a-b reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int n_chk;
  int n_pass;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_diff(input logic [31:0] x, input logic [31:0] y);
    return (x - y) & MASK;
  endfunction

  function automatic logic [31:0] ref_borrow(input logic [31:0] x, input logic [31:0] y);
    return (x < y) ? 32'd1 : 32'd0;
  endfunction

  // One complete operation; perturb re-asserts start and zeroes a/b while running.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input bit perturb,
                        input bit timing);
    int busy_n;
    int done_at;
    logic [WIDTH-1:0] d_cap;
    logic b_cap;
    @(negedge clk);
    a = ta[WIDTH-1:0];
    b = tb_[WIDTH-1:0];
    start = 1'b1;
    busy_n = 0;
    done_at = 0;
    d_cap = '0;
    b_cap = 1'b0;
    for (int c = 1; c <= WIDTH + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = perturb;
        if (perturb) begin
          a = '0;
          b = '0;
        end
      end
      if (perturb && c == WIDTH - 2) start = 1'b0;
      if (busy) busy_n++;
      if (done && done_at == 0) begin
        done_at = c;
        d_cap = diff;
        b_cap = borrow;
      end
    end
    check("diff", {24'd0, d_cap}, ref_diff(ta, tb_));
    check("borrow", {31'd0, b_cap}, ref_borrow(ta, tb_));
    if (timing) begin
      check("busy_cycles", busy_n, WIDTH);
      check("done_cycle", done_at, WIDTH + 1);
      check("diff_hold", {24'd0, diff}, ref_diff(ta, tb_));
      check("borrow_hold", {31'd0, borrow}, ref_borrow(ta, tb_));
    end
  endtask

  task automatic back_to_back();
    logic [31:0] qa[3];
    logic [31:0] qb[3];
    int dones;
    int last_done;
    qa = '{32'h80, 32'h10, 32'hAA};
    qb = '{32'h01, 32'h20, 32'h55};
    dones = 0;
    last_done = 0;
    @(negedge clk);
    a = qa[0][WIDTH-1:0];
    b = qb[0][WIDTH-1:0];
    start = 1'b1;
    for (int c = 1; c <= 60 && dones < 3; c++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_diff", {24'd0, diff}, ref_diff(qa[dones], qb[dones]));
        check("b2b_borrow", {31'd0, borrow}, ref_borrow(qa[dones], qb[dones]));
        if (dones > 0) check("b2b_spacing", c - last_done, WIDTH + 2);
        last_done = c;
        dones++;
        if (dones < 3) begin
          a = qa[dones][WIDTH-1:0];
          b = qb[dones][WIDTH-1:0];
        end else begin
          start = 1'b0;
        end
      end
    end
    check("b2b_count", dones, 3);
    start = 1'b0;
  endtask

  task automatic reset_mid_run();
    int done_seen;
    @(negedge clk);
    a = 8'h37;
    b = 8'h12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("rst_no_done", done_seen, 0);
    run_op(32'h09, 32'h04, 1'b0, 1'b1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    check("init_busy", {31'd0, busy}, 32'd0);
    check("init_done", {31'd0, done}, 32'd0);
    check("init_diff", {24'd0, diff}, 32'd0);
    check("init_borrow", {31'd0, borrow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h05, 32'h03, 1'b0, 1'b1);
    run_op(32'h03, 32'h05, 1'b0, 1'b1);
    run_op(32'h00, 32'h00, 1'b0, 1'b1);
    run_op(32'hFF, 32'h01, 1'b1, 1'b1);
    run_op(32'h00, 32'h01, 1'b0, 1'b1);
    run_op(32'h5A, 32'h5A, 1'b0, 1'b1);
    back_to_back();
    reset_mid_run();

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom & MASK;
      rb = $urandom & MASK;
      run_op(ra, rb, 1'b0, (i % 50) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
